// File: rtl/interval_timer_ctrl.sv
// Interval timer: prescaled tick counter with one-shot/periodic expiry,
// pause/resume, sticky irq and a rejected-start error pulse.
module interval_timer_ctrl #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             resume,
  input  logic [WIDTH-1:0] period,
  input  logic [PRE_W-1:0] prescale,
  input  logic             periodic,
  input  logic             irq_clear,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             expired,
  output logic             irq,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             periodic_q, periodic_d;
  logic             expired_d, irq_d, err_d;
  logic             tick, last_tick;

  assign tick      = (state_q == S_RUN) && (pre_cnt_q == prescale_q);
  // period_q is never 0 while running, so period_q-1 cannot wrap.
  assign last_tick = tick && (count_q == period_q - WIDTH'(1));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    count_d    = count_q;
    pre_cnt_d  = pre_cnt_q;
    expired_d  = 1'b0;
    err_d      = 1'b0;
    irq_d      = irq & ~irq_clear;

    if (stop) begin
      state_d   = S_IDLE;
      count_d   = '0;
      pre_cnt_d = '0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      if (period == '0) begin
        err_d = 1'b1;
      end else begin
        period_d   = period;
        prescale_d = prescale;
        periodic_d = periodic;
        count_d    = '0;
        pre_cnt_d  = '0;
        state_d    = S_RUN;
      end
    end else if (state_q == S_RUN) begin
      // The pause edge still advances the timer, so an expiry landing on it is kept.
      if (tick) begin
        pre_cnt_d = '0;
        if (last_tick) begin
          count_d   = '0;
          expired_d = 1'b1;
          irq_d     = 1'b1;
          if (!periodic_q) state_d = S_DONE;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
      if (pause && state_d == S_RUN) state_d = S_PAUSED;
    end else if (state_q == S_PAUSED && resume) begin
      state_d = S_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      count_q    <= '0;
      pre_cnt_q  <= '0;
      expired    <= 1'b0;
      irq        <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      count_q    <= count_d;
      pre_cnt_q  <= pre_cnt_d;
      expired    <= expired_d;
      irq        <= irq_d;
      err        <= err_d;
    end
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: the driver pushes the reference
// model's post-edge outputs, a monitor pops and compares one entry per edge.
module tb_interval_timer_ctrl;
  localparam int W  = 8;
  localparam int PW = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic          clock = 1'b0;
  logic          reset, start, stop, pause, resume, periodic, irq_clear;
  logic [W-1:0]  period;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic [1:0]    state;
  logic          expired, irq, err;

  interval_timer_ctrl #(.WIDTH(W), .PRE_W(PW)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .pause(pause), .resume(resume), .period(period), .prescale(prescale),
    .periodic(periodic), .irq_clear(irq_clear), .count(count),
    .state(state), .expired(expired), .irq(irq), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] count;
    logic [1:0]   state;
    logic         expired;
    logic         irq;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   exp_edges[$];
  int   passed = 0;
  int   total  = 0;
  int   edge_n = 0;

  // Reference model: time elapsed in RUN since load, count derived by division.
  int     m_st = M_IDLE;
  longint m_per = 0, m_psc = 0, m_elapsed = 0;
  bit     m_periodic = 0, m_irq = 0, m_expired = 0, m_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic void model_step(input bit r, s, sp, pa, re, clr,
                                     input int per, input int psc, input bit pm);
    bit exp_now = 0;
    bit irq_next;
    if (r) begin
      m_st = M_IDLE; m_per = 0; m_psc = 0; m_periodic = 0; m_elapsed = 0;
      m_irq = 0; m_expired = 0; m_err = 0;
      return;
    end
    m_err    = 0;
    irq_next = m_irq && !clr;
    if (sp) begin
      m_st = M_IDLE;
      m_elapsed = 0;
    end else if (s && (m_st == M_IDLE || m_st == M_DONE)) begin
      if (per == 0) m_err = 1;
      else begin
        m_per = per; m_psc = psc; m_periodic = pm; m_elapsed = 0; m_st = M_RUN;
      end
    end else if (m_st == M_RUN) begin
      m_elapsed++;
      if (m_elapsed == m_per * (m_psc + 1)) begin
        m_elapsed = 0;
        exp_now   = 1;
        if (!m_periodic) m_st = M_DONE;
      end
      if (pa && m_st == M_RUN) m_st = M_PAUSED;
    end else if (m_st == M_PAUSED && re) begin
      m_st = M_RUN;
    end
    m_expired = exp_now;
    m_irq     = irq_next || exp_now;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.count   = W'(m_elapsed / (m_psc + 1));
    e.state   = 2'(m_st);
    e.expired = m_expired;
    e.irq     = m_irq;
    e.err     = m_err;
    return e;
  endfunction

  task automatic apply(input bit r, s, sp, pa, re, clr,
                       input int per, input int psc, input bit pm);
    @(negedge clock);
    reset = r; start = s; stop = sp; pause = pa; resume = re; irq_clear = clr;
    period = W'(per); prescale = PW'(psc); periodic = pm;
    model_step(r, s, sp, pa, re, clr, per, psc, pm);
    sb.push_back(snapshot());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int gap(input int idx, input int base);
    if (idx < exp_edges.size()) return exp_edges[idx] - base;
    return -1;
  endfunction

  // Monitor: one expected entry per edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      edge_n++;
      if (expired) exp_edges.push_back(edge_n);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("count", count, e.count);
        check("state", state, e.state);
        check("flags{exp,irq,err}", {expired, irq, err}, {e.expired, e.irq, e.err});
      end
    end
  end

  initial begin
    int s_edge;
    int r;
    reset = 1; start = 0; stop = 0; pause = 0; resume = 0; irq_clear = 0;
    period = '0; prescale = '0; periodic = 0;

    for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // One-shot, period 3: expiry 3 edges after start, then DONE with irq.
    exp_edges.delete();
    apply(0, 1, 0, 0, 0, 0, 3, 0, 0);
    s_edge = edge_n + 1;
    idle(6);
    check("oneshot_latency", gap(0, s_edge), 3);
    check("oneshot_pulses", exp_edges.size(), 1);

    // Periodic, period 3, prescale 1: expiries at 6, 12, 18.
    exp_edges.delete();
    apply(0, 1, 0, 0, 0, 0, 3, 1, 1);
    s_edge = edge_n + 1;
    idle(20);
    check("periodic_exp1", gap(0, s_edge), 6);
    check("periodic_exp2", gap(1, s_edge), 12);
    check("periodic_exp3", gap(2, s_edge), 18);
    apply(0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Pause at count 4 for 5 cycles: expiry moves from 10 to 15.
    exp_edges.delete();
    apply(0, 1, 0, 0, 0, 0, 10, 0, 0);
    s_edge = edge_n + 1;
    idle(3);
    apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(4);
    apply(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(10);
    check("pause_delayed_exp", gap(0, s_edge), 15);

    // Zero period rejected, then period 2 accepted.
    apply(0, 0, 1, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 2, 0, 0);
    idle(3);

    // Stop on the expiring edge suppresses the expiry.
    exp_edges.delete();
    apply(0, 1, 0, 0, 0, 0, 2, 0, 0);
    idle(1);
    apply(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    check("stop_beats_expiry", exp_edges.size(), 0);

    // irq_clear on an expiry edge keeps irq; on a quiet edge clears it.
    apply(0, 1, 0, 0, 0, 0, 2, 0, 1);
    idle(1);
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Reset mid-run at count 7 overrides simultaneous commands; start right after.
    apply(0, 1, 0, 0, 0, 0, 10, 0, 0);
    idle(7);
    apply(1, 1, 1, 1, 0, 0, 5, 0, 0);
    apply(1, 1, 0, 1, 0, 0, 5, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 4, 0, 0);
    idle(5);

    // Maximum period with no overflow.
    exp_edges.delete();
    apply(0, 1, 0, 0, 0, 0, 255, 0, 0);
    s_edge = edge_n + 1;
    idle(260);
    check("max_period_latency", gap(0, s_edge), 255);

    // Randomized commands against the model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      apply($urandom_range(0, 199) == 0,
            r < 10,
            r >= 10 && r < 13,
            (r >= 13 && r < 22) || r == 99,
            (r >= 22 && r < 32) || r == 99,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    idle(2);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the width of the counter, period and count output.
REQ-002 The block SHALL have parameter PRE_W, default 8, giving the width of the prescaler.
REQ-003 Port clock  input  1  the only clock; all logic SHALL be on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle command that loads the configuration and begins timing.
REQ-006 Port stop  input  1  single-cycle command that aborts timing and returns the block to IDLE.
REQ-007 Port pause  input  1  single-cycle command that freezes a running timer.
REQ-008 Port resume  input  1  single-cycle command that continues a paused timer.
REQ-009 Port period  input  WIDTH  ticks per expiry; sampled only when start is accepted.
REQ-010 Port prescale  input  PRE_W  clock cycles per tick minus one; sampled only when start is accepted.
REQ-011 Port periodic  input  1  1 = auto-reload, 0 = one-shot; sampled only when start is accepted.
REQ-012 Port irq_clear  input  1  clears the sticky irq output.
REQ-013 Port count  output  WIDTH  current tick count.
REQ-014 Port state  output  2  current state: IDLE=0, RUN=1, PAUSED=2, DONE=3.
REQ-015 Port expired  output  1  registered one-cycle pulse per expiry.
REQ-016 Port irq  output  1  sticky expiry flag.
REQ-017 Port err  output  1  registered one-cycle pulse on a rejected start.

Function
REQ-018 The block SHALL implement a state machine with states IDLE, RUN, PAUSED and DONE.
REQ-019 A start in IDLE or DONE with period != 0 SHALL latch period, prescale and periodic, clear count and the prescaler, and enter RUN on the same edge.
REQ-020 A start with period == 0 SHALL be rejected: state is unchanged and err pulses for 1 cycle.
REQ-021 A start in RUN or PAUSED SHALL be ignored, with no err pulse.
REQ-022 In RUN, the prescaler SHALL increment each cycle and produce a tick when it equals the latched prescale, wrapping to 0 on that tick; prescale=0 produces a tick every cycle.
REQ-023 On a tick with count != period-1, count SHALL increment by 1.
REQ-024 On a tick with count == period-1, count SHALL become 0, expired SHALL pulse for the next cycle, and irq SHALL set.
REQ-025 On that expiring tick, a periodic timer SHALL stay in RUN and a one-shot timer SHALL go to DONE.
REQ-026 The first expired pulse SHALL assert exactly period*(prescale+1) edges after the edge that accepted start.
REQ-027 Count SHALL never exceed period-1; the maximum period 2^WIDTH-1 SHALL work with no overflow.
REQ-028 A pause in RUN SHALL enter PAUSED, holding count and the prescaler frozen.
REQ-029 A pause in any other state SHALL be ignored.
REQ-030 A resume in PAUSED SHALL return to RUN, continuing from the frozen values; a resume in any other state SHALL be ignored.
REQ-031 A stop in any state SHALL enter IDLE and clear count and the prescaler.
REQ-032 Command priority SHALL be stop > start > pause/resume; simultaneous pause and resume in RUN SHALL act as pause only.
REQ-033 Stop coincident with an expiring tick SHALL win: no expired pulse and no irq set.
REQ-034 Pause coincident with an expiring tick SHALL still process the expiry; the result is PAUSED if periodic, or DONE if one-shot.
REQ-035 irq SHALL remain set until irq_clear; if irq_clear coincides with a new expiry, irq SHALL stay 1.
REQ-036 DONE SHALL hold count=0 until start or stop.

Reset
REQ-037 Reset asserted at a clock edge SHALL force state=IDLE, count=0, prescaler=0, expired=0, irq=0, err=0, and latched period/prescale/periodic=0.
REQ-038 Reset SHALL take priority over every command, including during RUN or PAUSED mid-count.
REQ-039 After reset is released, the block SHALL accept start on the next edge.

Verification
REQ-040 Reset, then start with period=3, prescale=0, periodic=0 -> count goes 0,1,2,0; expired pulses once, 3 edges after start; state=DONE; irq=1.
REQ-041 Start with period=3, prescale=1, periodic=1 -> expired pulses at edges 6, 12 and 18 after start; state stays RUN.
REQ-042 Run with period=10, prescale=0; pause at count=4, hold 5 cycles, then resume -> count stays 4 while paused; expiry is delayed by exactly 5 cycles.
REQ-043 Start with period=0 -> err pulses 1 cycle; state stays IDLE; a later start with period=2 is accepted.
REQ-044 Stop on the same edge as an expiring tick -> state=IDLE, count=0, no expired pulse, irq unchanged; separately, irq_clear coincident with an expiry -> irq=1.
REQ-045 Assert reset mid-RUN at count=7 -> all outputs read their reset values on the next cycle, and start/stop/pause issued during reset are ignored.
